// File: rtl/demux_deser_pkg.sv
// Shared definitions for the serial-to-parallel capture block: bit-order encodings
// and the mapping from frame slot index to capture register bit position.
package demux_deser_pkg;

    localparam int ORDER_LSB_FIRST = 0;
    localparam int ORDER_MSB_FIRST = 1;

    // Mapping is its own inverse, so it also converts a capture bit back to its slot.
    function automatic int map_slot(input int idx, input int width, input int order);
        return (order == ORDER_MSB_FIRST) ? (width - 1 - idx) : idx;
    endfunction

endpackage

// File: rtl/demux_deser_slot_ctr.sv
// Mod-DATA_WIDTH slot counter acting as the demux select; registered sel, combinational decode.
// No backpressure of its own: advances only on inc_i, jumps to slot 1 on restart_i.
module demux_deser_slot_ctr
    import demux_deser_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    localparam int SEL_WIDTH  = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inc_i,
    input  logic                  restart_i,
    output logic [SEL_WIDTH-1:0]  sel_o,
    output logic                  last_o,
    output logic [DATA_WIDTH-1:0] dec_o
);

    localparam logic [SEL_WIDTH-1:0] SEL_LAST = SEL_WIDTH'(DATA_WIDTH - 1);
    localparam logic [SEL_WIDTH-1:0] SEL_ONE  = SEL_WIDTH'(1);

    logic [SEL_WIDTH-1:0] sel_q;
    logic [SEL_WIDTH-1:0] sel_d;

    assign sel_o  = sel_q;
    assign last_o = (sel_q == SEL_LAST);

    // A sync bit occupies slot 0, so the restart target is the slot after it.
    always_comb begin
        sel_d = sel_q;
        if (restart_i) begin
            sel_d = SEL_ONE;
        end else if (inc_i) begin
            sel_d = last_o ? '0 : sel_q + SEL_ONE;
        end
    end

    always_comb begin
        dec_o = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            dec_o[i] = (sel_q == SEL_WIDTH'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q <= '0;
        end else begin
            sel_q <= sel_d;
        end
    end

endmodule

// File: rtl/demux_deser.sv
// Serial-to-parallel capture: out_valid rises one cycle after the DATA_WIDTH-th accepted bit.
// in_ready drops only when a completing bit would land on an unpopped holding word.
module demux_deser
    import demux_deser_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int MSB_FIRST  = ORDER_LSB_FIRST,
    localparam int SEL_WIDTH  = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_bit,
    input  logic                  in_valid,
    input  logic                  in_sync,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SEL_WIDTH-1:0]  sel,
    output logic                  frame_err
);

    localparam int SYNC_BIT = map_slot(0, DATA_WIDTH, MSB_FIRST);

    logic                  acc;
    logic                  sync_acc;
    logic                  bit_acc;
    logic                  last;
    logic                  complete;
    logic [DATA_WIDTH-1:0] dec;
    logic [DATA_WIDTH-1:0] wr_en;

    logic [DATA_WIDTH-1:0] cap_q;
    logic [DATA_WIDTH-1:0] cap_d;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [DATA_WIDTH-1:0] out_data_d;
    logic                  out_valid_q;
    logic                  out_valid_d;
    logic                  frame_err_q;
    logic                  frame_err_d;

    // A sync bit never completes a word, so it is never stalled.
    assign in_ready = !(last && !(in_valid && in_sync) && out_valid_q && !out_ready);
    assign acc      = in_valid && in_ready;
    assign sync_acc = acc && in_sync;
    assign bit_acc  = acc && !in_sync;
    assign complete = bit_acc && last;

    demux_deser_slot_ctr #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_slot_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc_i     (bit_acc),
        .restart_i (sync_acc),
        .sel_o     (sel),
        .last_o    (last),
        .dec_o     (dec)
    );

    // Demux: capture bit g is written by the slot that maps onto it.
    for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_wr_en
        localparam int SLOT = map_slot(g, DATA_WIDTH, MSB_FIRST);
        assign wr_en[g] = bit_acc && dec[SLOT];
    end

    always_comb begin
        cap_d = cap_q;
        if (sync_acc) begin
            cap_d           = '0;
            cap_d[SYNC_BIT] = in_bit;
        end else begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                if (wr_en[i]) begin
                    cap_d[i] = in_bit;
                end
            end
        end
    end

    // A completion in the same cycle as a pop replaces the word without a bubble.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (complete) begin
            out_valid_d = 1'b1;
            out_data_d  = cap_d;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    assign frame_err_d = sync_acc && (sel != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            cap_q       <= cap_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_demux_deser.sv
// Directed bench for demux_deser: LSB-first and MSB-first 8-bit instances plus a 5-bit
// instance, all driven by one shared stimulus stream.
module tb_demux_deser;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_bit, in_valid, in_sync, out_ready;

    logic       rdy8, ovld8, ferr8;
    logic [7:0] data8;
    logic [2:0] sel8;
    logic       rdy8m, ovld8m, ferr8m;
    logic [7:0] data8m;
    logic [2:0] sel8m;
    logic       rdy5, ovld5, ferr5;
    logic [4:0] data5;
    logic [2:0] sel5;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    demux_deser #(.DATA_WIDTH(8), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .in_bit(in_bit), .in_valid(in_valid), .in_sync(in_sync),
        .in_ready(rdy8), .out_data(data8), .out_valid(ovld8), .out_ready(out_ready),
        .sel(sel8), .frame_err(ferr8)
    );

    demux_deser #(.DATA_WIDTH(8), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst_n(rst_n), .in_bit(in_bit), .in_valid(in_valid), .in_sync(in_sync),
        .in_ready(rdy8m), .out_data(data8m), .out_valid(ovld8m), .out_ready(out_ready),
        .sel(sel8m), .frame_err(ferr8m)
    );

    demux_deser #(.DATA_WIDTH(5), .MSB_FIRST(0)) u_w5 (
        .clk(clk), .rst_n(rst_n), .in_bit(in_bit), .in_valid(in_valid), .in_sync(in_sync),
        .in_ready(rdy5), .out_data(data5), .out_valid(ovld5), .out_ready(out_ready),
        .sel(sel5), .frame_err(ferr5)
    );

    typedef struct {
        bit         v;
        bit         s;
        bit         b;
        bit         r;
        int         sel;
        bit         rdy;
        bit         ovld;
        logic [7:0] dl;
        logic [7:0] dm;
        bit         ferr;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input bit v, input bit s, input bit b, input bit r);
        in_valid  = v;
        in_sync   = s;
        in_bit    = b;
        out_ready = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input bit v, s, b, r, input int sl, input bit rd, ov,
                       input logic [7:0] dl, dm, input bit fe);
        vec_t t;
        t = '{v, s, b, r, sl, rd, ov, dl, dm, fe};
        tbl.push_back(t);
    endtask

    initial begin
        logic [7:0] wa;
        logic [7:0] wb;
        logic [7:0] wc;
        logic [9:0] s5;
        logic [4:0] w5;
        int         words;

        rst_n = 1'b0;
        drive(0, 0, 0, 1);
        #22;
        chk("rst_sel", 0, sel8, 0);
        chk("rst_ovld", 0, ovld8, 0);
        chk("rst_data", 0, data8, 0);
        chk("rst_ferr", 0, ferr8, 0);
        chk("rst_rdy", 0, rdy8, 1);
        chk("rst_sel5", 0, sel5, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Frame 1: bits 1,0,1,1,0,0,1,0 with sync on bit 0.
        add(1,1,1,1, 0,1,0, 8'h00,8'h00,0);
        add(1,0,0,1, 1,1,0, 8'h00,8'h00,0);
        add(1,0,1,1, 2,1,0, 8'h00,8'h00,0);
        add(1,0,1,1, 3,1,0, 8'h00,8'h00,0);
        add(1,0,0,1, 4,1,0, 8'h00,8'h00,0);
        add(1,0,0,1, 5,1,0, 8'h00,8'h00,0);
        add(1,0,1,1, 6,1,0, 8'h00,8'h00,0);
        add(1,0,0,1, 7,1,1, 8'h4D,8'hB2,0);
        add(0,0,0,1, 0,1,0, 8'h4D,8'hB2,0);
        // Partial frame with an idle gap, then resync at slot 5.
        add(1,1,1,1, 0,1,0, 8'h4D,8'hB2,0);
        add(1,0,1,1, 1,1,0, 8'h4D,8'hB2,0);
        add(1,0,1,1, 2,1,0, 8'h4D,8'hB2,0);
        add(0,0,0,1, 3,1,0, 8'h4D,8'hB2,0);
        add(1,0,1,1, 3,1,0, 8'h4D,8'hB2,0);
        add(1,0,1,1, 4,1,0, 8'h4D,8'hB2,0);
        add(1,1,0,1, 5,1,0, 8'h4D,8'hB2,1);
        add(1,0,1,1, 1,1,0, 8'h4D,8'hB2,0);
        add(1,0,1,1, 2,1,0, 8'h4D,8'hB2,0);
        add(1,0,0,1, 3,1,0, 8'h4D,8'hB2,0);
        add(1,0,0,1, 4,1,0, 8'h4D,8'hB2,0);
        add(1,0,0,1, 5,1,0, 8'h4D,8'hB2,0);
        add(1,0,0,1, 6,1,0, 8'h4D,8'hB2,0);
        add(1,0,1,1, 7,1,1, 8'h86,8'h61,0);
        add(0,0,0,1, 0,1,0, 8'h86,8'h61,0);

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].s, tbl[i].b, tbl[i].r);
            #1;
            chk("vec_sel", i, sel8, tbl[i].sel);
            chk("vec_rdy", i, rdy8, tbl[i].rdy);
            tick();
            chk("vec_ovld", i, ovld8, tbl[i].ovld);
            chk("vec_data_lsb", i, data8, tbl[i].dl);
            chk("vec_data_msb", i, data8m, tbl[i].dm);
            chk("vec_ferr", i, ferr8, tbl[i].ferr);
            chk("vec_ferr_msb", i, ferr8m, tbl[i].ferr);
        end

        // One-hot walk: 8 back-to-back frames, 64 cycles, 8 words.
        words = 0;
        for (int f = 0; f < 8; f++) begin
            for (int k = 0; k < 8; k++) begin
                drive(1, k == 0, k == f, 1);
                #1;
                chk("walk_sel", f * 8 + k, sel8, k);
                tick();
                if (ovld8) words++;
                if (k == 7) begin
                    chk("walk_ovld", f, ovld8, 1);
                    chk("walk_lsb", f, data8, 32'(1) << f);
                    chk("walk_msb", f, data8m, 32'(1) << (7 - f));
                end
            end
        end
        chk("walk_words", 0, words, 8);
        drive(0, 0, 0, 1);
        tick();
        chk("walk_pop", 0, ovld8, 0);

        // Backpressure: second frame stalls at its last slot until the first word pops.
        wa = 8'h3C;
        wb = 8'hC3;
        for (int k = 0; k < 8; k++) begin
            drive(1, k == 0, wa[k], 0);
            #1;
            chk("bp_a_rdy", k, rdy8, 1);
            tick();
        end
        chk("bp_a_ovld", 0, ovld8, 1);
        chk("bp_a_data", 0, data8, 8'h3C);
        for (int k = 0; k < 7; k++) begin
            drive(1, k == 0, wb[k], 0);
            #1;
            chk("bp_b_rdy", k, rdy8, 1);
            tick();
        end
        drive(1, 0, wb[7], 0);
        #1;
        chk("bp_stall_rdy", 0, rdy8, 0);
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("bp_hold_rdy", c, rdy8, 0);
            chk("bp_hold_sel", c, sel8, 7);
            chk("bp_hold_data", c, data8, 8'h3C);
            chk("bp_hold_ovld", c, ovld8, 1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_rdy", 0, rdy8, 1);
        tick();
        chk("bp_swap_ovld", 0, ovld8, 1);
        chk("bp_swap_data", 0, data8, 8'hC3);
        chk("bp_swap_sel", 0, sel8, 0);
        drive(0, 0, 0, 1);
        tick();
        chk("bp_drain_ovld", 0, ovld8, 0);

        // Reset mid-frame with a word held.
        wc = 8'h5A;
        for (int k = 0; k < 8; k++) begin
            drive(1, k == 0, wc[k], 0);
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 1, 0);
            tick();
        end
        drive(0, 0, 0, 0);
        #1;
        chk("pre_rst_sel", 0, sel8, 3);
        chk("pre_rst_ovld", 0, ovld8, 1);
        chk("pre_rst_data", 0, data8, 8'h5A);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_ovld", 0, ovld8, 0);
        chk("async_rst_sel", 0, sel8, 0);
        chk("async_rst_data", 0, data8, 0);
        chk("async_rst_sel5", 0, sel5, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Width-5 run without sync: first accepted bit is slot 0, sel wraps 4->0.
        s5 = 10'b11_1000_1011;
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, s5[i], 1);
            #1;
            chk("w5_sel", i, sel5, i % 5);
            if (i == 0) chk("post_rst_sel8", 0, sel8, 0);
            tick();
            if (i == 0) chk("post_rst_sel8_adv", 0, sel8, 1);
            if (i % 5 == 4) begin
                w5 = (i == 4) ? s5[4:0] : s5[9:5];
                chk("w5_ovld", i, ovld5, 1);
                chk("w5_data", i, data5, w5);
            end else begin
                chk("w5_idle", i, ovld5, 0);
            end
        end
        drive(0, 0, 0, 1);
        #1;
        chk("w5_wrap_sel", 0, sel5, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
